// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch front end bus: imem request/response, redirect, decode channel
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic [ADDR_W-1:0] dec_pcplus4;
  logic              dec_ready;

  // The fetch unit itself
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_pcplus4,
    input  dec_ready
  );

  // Memory, branch unit and decode as seen from outside
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_pcplus4,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - decoupled instruction fetch: credit-limited requests, in-order response queue, redirect flush
module fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_queue_if.master     bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; responses return in order and all
  // kept in-flight requests are sequential from here, so one register replaces a PC FIFO.
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  cnt_t              count_q, count_d;
  cnt_t              inflight_q, inflight_d;
  cnt_t              drop_q, drop_d;
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic              credit_ok;
  logic              req_valid;
  logic              req_fire;
  logic              rsp_fire;
  logic              dropping;
  logic              push;
  logic              dec_valid;
  logic              pop;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

  // Request and queue control decodes
  always_comb begin
    credit_ok        = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C;
    req_valid        = rst_n & ~bus.redirect_valid & credit_ok;
    req_fire         = req_valid & bus.imem_req_ready;
    rsp_fire         = bus.imem_rsp_valid & (inflight_q != '0);
    dropping         = rsp_fire & (drop_q != '0);
    push             = rsp_fire & ~dropping & ~bus.redirect_valid;
    dec_valid        = rst_n & (count_q != '0);
    pop              = dec_valid & bus.dec_ready & ~bus.redirect_valid;
    redirect_aligned = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  end

  // Next-state: normal fetch/push/pop, then redirect overrides queue and fetch state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
    count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (dropping) drop_d = drop_q - cnt_t'(1);
    if (push) begin
      tail_d   = tail_q + ptr_t'(1);
      rsp_pc_d = rsp_pc_q + ADDR_W'(4);
    end
    if (pop) head_d = head_q + ptr_t'(1);
    if (bus.redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_d     = inflight_d;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage: instruction and its PC written together at the tail
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      instr_mem[tail_q] <= bus.imem_rsp_data;
      pc_mem[tail_q]    <= rsp_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = instr_mem[head_q];
  assign bus.dec_pc         = pc_mem[head_q];
  assign bus.dec_pcplus4    = pc_mem[head_q] + ADDR_W'(4);
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   sel = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
  fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.master));
  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.master));

  typedef struct {
    logic        rs;
    logic        rdy;
    logic        rv;
    logic [31:0] ra;
    logic        rd;
    logic [31:0] rpc;
    logic        dr;
    logic        erv;
    logic        ca;
    logic [31:0] ea;
    logic        edv;
    logic [31:0] ep;
  } vec_t;

  // Instruction word memory returns for a given fetch address
  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t v(input logic rs, input logic rdy, input logic rv, input logic [31:0] ra,
                             input logic rd, input logic [31:0] rpc, input logic dr,
                             input logic erv, input logic ca, input logic [31:0] ea,
                             input logic edv, input logic [31:0] ep);
    vec_t t;
    t.rs = rs; t.rdy = rdy; t.rv = rv; t.ra = ra; t.rd = rd; t.rpc = rpc; t.dr = dr;
    t.erv = erv; t.ca = ca; t.ea = ea; t.edv = edv; t.ep = ep;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input vec_t t, input string tag);
    logic        o_rv, o_dv;
    logic [31:0] o_ra, o_di, o_pc, o_p4;
    @(negedge clk);
    rst_n = t.rs;
    if_a.imem_req_ready = t.rdy; if_a.imem_rsp_valid = t.rv; if_a.imem_rsp_data = dat(t.ra);
    if_a.redirect_valid = t.rd;  if_a.redirect_pc = t.rpc;   if_a.dec_ready = t.dr;
    if_b.imem_req_ready = t.rdy; if_b.imem_rsp_valid = t.rv; if_b.imem_rsp_data = dat(t.ra);
    if_b.redirect_valid = t.rd;  if_b.redirect_pc = t.rpc;   if_b.dec_ready = t.dr;
    #2;
    if (sel == 0) begin
      o_rv = if_a.imem_req_valid; o_ra = if_a.imem_req_addr; o_dv = if_a.dec_valid;
      o_di = if_a.dec_instr; o_pc = if_a.dec_pc; o_p4 = if_a.dec_pcplus4;
    end else begin
      o_rv = if_b.imem_req_valid; o_ra = if_b.imem_req_addr; o_dv = if_b.dec_valid;
      o_di = if_b.dec_instr; o_pc = if_b.dec_pc; o_p4 = if_b.dec_pcplus4;
    end
    chk({tag, " req_valid"}, {31'd0, o_rv}, {31'd0, t.erv});
    if (t.ca) chk({tag, " req_addr"}, o_ra, t.ea);
    chk({tag, " dec_valid"}, {31'd0, o_dv}, {31'd0, t.edv});
    if (t.edv) begin
      chk({tag, " dec_pc"}, o_pc, t.ep);
      chk({tag, " dec_instr"}, o_di, dat(t.ep));
      chk({tag, " dec_pcplus4"}, o_p4, t.ep + 32'd4);
    end
  endtask

  vec_t tbl[$];

  initial begin
    if_a.imem_req_ready = 1'b0; if_a.imem_rsp_valid = 1'b0; if_a.imem_rsp_data = '0;
    if_a.redirect_valid = 1'b0; if_a.redirect_pc = '0;      if_a.dec_ready = 1'b0;
    if_b.imem_req_ready = 1'b0; if_b.imem_rsp_valid = 1'b0; if_b.imem_rsp_data = '0;
    if_b.redirect_valid = 1'b0; if_b.redirect_pc = '0;      if_b.dec_ready = 1'b0;

    // Streaming fetch, latency-1 memory, decode always ready
    //             rs rdy rv ra         rd rpc dr erv ca ea          edv ep
    tbl.push_back(v(0, 0, 0, 32'h0,     0, 0,  0, 0,  0, 32'h0,      0, 32'h0));
    tbl.push_back(v(1, 1, 0, 32'h0,     0, 0,  1, 1,  1, 32'h0,      0, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h0,     0, 0,  1, 1,  1, 32'h4,      0, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h4,     0, 0,  1, 1,  1, 32'h8,      1, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h8,     0, 0,  1, 1,  1, 32'hC,      1, 32'h4));
    tbl.push_back(v(1, 1, 1, 32'hC,     0, 0,  1, 1,  1, 32'h10,     1, 32'h8));
    // Decode stalled: four requests fill the credit, then drain and resume at 0x10
    tbl.push_back(v(0, 0, 0, 32'h0,     0, 0,  0, 0,  0, 32'h0,      0, 32'h0));
    tbl.push_back(v(1, 1, 0, 32'h0,     0, 0,  0, 1,  1, 32'h0,      0, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h0,     0, 0,  0, 1,  1, 32'h4,      0, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h4,     0, 0,  0, 1,  1, 32'h8,      1, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'h8,     0, 0,  0, 1,  1, 32'hC,      1, 32'h0));
    tbl.push_back(v(1, 1, 1, 32'hC,     0, 0,  0, 0,  1, 32'h10,     1, 32'h0));
    tbl.push_back(v(1, 1, 0, 32'h0,     0, 0,  0, 0,  1, 32'h10,     1, 32'h0));
    tbl.push_back(v(1, 1, 0, 32'h0,     0, 0,  1, 0,  1, 32'h10,     1, 32'h0));
    tbl.push_back(v(1, 1, 0, 32'h0,     0, 0,  1, 1,  1, 32'h10,     1, 32'h4));
    tbl.push_back(v(1, 1, 1, 32'h10,    0, 0,  1, 1,  1, 32'h14,     1, 32'h8));
    tbl.push_back(v(1, 1, 1, 32'h14,    0, 0,  1, 1,  1, 32'h18,     1, 32'hC));
    tbl.push_back(v(1, 0, 0, 32'h0,     0, 0,  1, 1,  1, 32'h1C,     1, 32'h10));
    tbl.push_back(v(1, 0, 0, 32'h0,     0, 0,  1, 1,  1, 32'h1C,     1, 32'h14));
    tbl.push_back(v(1, 0, 1, 32'h18,    0, 0,  1, 1,  1, 32'h1C,     0, 32'h0));
    tbl.push_back(v(1, 0, 0, 32'h0,     0, 0,  1, 1,  1, 32'h1C,     1, 32'h18));

    sel = 0;
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Redirect with two requests in flight: both stale responses dropped
    apply(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0),   "rd_s0");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0),   "rd_s1");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h4,   0, 32'h0),   "rd_s2");
    apply(v(1, 1, 0, 32'h0,   1, 32'h100, 1, 0, 1, 32'h8,   0, 32'h0),   "rd_s3");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h100, 0, 32'h0),   "rd_s4");
    apply(v(1, 1, 1, 32'h0,   0, 32'h0,   1, 1, 1, 32'h104, 0, 32'h0),   "rd_s5");
    apply(v(1, 1, 1, 32'h4,   0, 32'h0,   1, 1, 1, 32'h108, 0, 32'h0),   "rd_s6");
    apply(v(1, 1, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h10C, 0, 32'h0),   "rd_s7");
    apply(v(1, 1, 1, 32'h104, 0, 32'h0,   1, 0, 1, 32'h110, 1, 32'h100), "rd_s8");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h110, 1, 32'h104), "rd_s9");
    apply(v(1, 0, 1, 32'h108, 0, 32'h0,   1, 1, 1, 32'h114, 0, 32'h0),   "rd_s10");
    // Redirect to unaligned 0x103 coinciding with pop and a response
    apply(v(1, 0, 1, 32'h10C, 1, 32'h103, 1, 0, 1, 32'h114, 1, 32'h108), "rd2_s11");
    apply(v(1, 1, 1, 32'h110, 0, 32'h0,   1, 1, 1, 32'h100, 0, 32'h0),   "rd2_s12");
    apply(v(1, 1, 1, 32'h100, 0, 32'h0,   1, 1, 1, 32'h104, 0, 32'h0),   "rd2_s13");
    apply(v(1, 1, 1, 32'h104, 0, 32'h0,   1, 1, 1, 32'h108, 1, 32'h100), "rd2_s14");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h10C, 1, 32'h104), "rd2_s15");
    apply(v(1, 0, 1, 32'h108, 0, 32'h0,   1, 1, 1, 32'h10C, 0, 32'h0),   "rd2_s16");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h10C, 1, 32'h108), "rd2_s17");
    // Response with nothing in flight is ignored
    apply(v(1, 0, 1, 32'h1F0, 0, 32'h0,   1, 1, 1, 32'h10C, 0, 32'h0),   "perr_s18");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h10C, 0, 32'h0),   "perr_s19");
    // Reset with queued entries and two requests in flight
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h10C, 0, 32'h0),   "rst_s20");
    apply(v(1, 1, 1, 32'h10C, 0, 32'h0,   0, 1, 1, 32'h110, 0, 32'h0),   "rst_s21");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h114, 1, 32'h10C), "rst_s22");
    apply(v(1, 1, 1, 32'h110, 0, 32'h0,   0, 1, 1, 32'h118, 1, 32'h10C), "rst_s23");
    apply(v(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0),   "rst_s24");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h0,   0, 32'h0),   "rst_s25");
    // Memory back-pressure holds the address at 0x8
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h4,   0, 32'h0),   "bp_s26");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h8,   0, 32'h0),   "bp_s27");
    apply(v(1, 0, 1, 32'h0,   0, 32'h0,   1, 1, 1, 32'h8,   0, 32'h0),   "bp_s28");
    apply(v(1, 0, 1, 32'h4,   0, 32'h0,   0, 1, 1, 32'h8,   1, 32'h0),   "bp_s29");
    apply(v(1, 1, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'h8,   1, 32'h0),   "bp_s30");
    apply(v(1, 0, 1, 32'h8,   0, 32'h0,   1, 1, 1, 32'hC,   1, 32'h4),   "bp_s31");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'hC,   1, 32'h8),   "bp_s32");
    apply(v(1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 1, 32'hC,   0, 32'h0),   "bp_s33");

    // Address wrap from RESET_PC = 0xFFFFFFFC
    sel = 1;
    apply(v(0, 0, 0, 32'h0,         0, 32'h0, 0, 0, 0, 32'h0,         0, 32'h0),         "wrap_w0");
    apply(v(1, 1, 0, 32'h0,         0, 32'h0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0),         "wrap_w1");
    apply(v(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 1, 1, 32'h0,         0, 32'h0),         "wrap_w2");
    apply(v(1, 1, 1, 32'h0,         0, 32'h0, 1, 1, 1, 32'h4,         1, 32'hFFFF_FFFC), "wrap_w3");
    apply(v(1, 1, 1, 32'h4,         0, 32'h0, 1, 1, 1, 32'h8,         1, 32'h0),         "wrap_w4");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
